// File: rtl/rlbp_pixel_sequencer.sv
// RLBP pixel timing sequencer: one shared time base per pixel drives all
// analog phase windows, then each pixel result is handed to the P2S stage.

module rlbp_phase_lane #(
    parameter int TW = 11
) (
    input  logic [TW-1:0] up,
    input  logic [TW-1:0] down,
    input  logic [TW-1:0] tcount,
    input  logic          en,
    output logic          hit
);
    // up >= down can never satisfy both bounds, so such a channel stays low
    assign hit = en && (tcount >= up) && (tcount < down);
endmodule

module rlbp_pixel_sequencer #(
    parameter int CH = 8,
    parameter int TW = 11,
    parameter int PW = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           abort,
    input  logic [CH*TW-1:0] time_up,
    input  logic [CH*TW-1:0] time_down,
    input  logic [TW-1:0]  period,
    input  logic [PW-1:0]  num_pix,
    input  logic           p2s_ready,
    output logic [CH-1:0]  phase_o,
    output logic           p2s_en,
    output logic [TW-1:0]  tcount,
    output logic [PW-1:0]  pix_idx,
    output logic           busy,
    output logic           done,
    output logic           cfg_err
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_XFER, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic [CH-1:0][TW-1:0] up;
        logic [CH-1:0][TW-1:0] down;
        logic [TW-1:0]         period;
        logic [PW-1:0]         num_pix;
    } cfg_t;

    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    state_t        state_q, state_d;
    cfg_t          sh;
    logic [CH-1:0] hit;
    logic          start_ok, accept, cfg_set, last_tick, last_pix;

    // abort beats start even while idle
    assign start_ok  = (state_q == S_IDLE) && start && !abort;
    assign cfg_set   = start_ok && (period == '0);
    assign accept    = start_ok && (period != '0);
    assign last_tick = (tcount == sh.period - T_ONE);
    assign last_pix  = (pix_idx == sh.num_pix - P_ONE);

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign p2s_en = (state_q == S_XFER);

    for (genvar k = 0; k < CH; k++) begin : g_lane
        rlbp_phase_lane #(.TW(TW)) u_lane (
            .up    (sh.up[k]),
            .down  (sh.down[k]),
            .tcount(tcount),
            .en    (state_q == S_RUN),
            .hit   (hit[k])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (num_pix == '0) ? S_DONE : S_RUN;
            S_RUN:  if (last_tick) state_d = S_XFER;
            S_XFER: state_d = S_WAIT;
            S_WAIT: if (p2s_ready) state_d = last_pix ? S_DONE : S_RUN;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh      <= '0;
            tcount  <= '0;
            pix_idx <= '0;
            phase_o <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (accept) begin
                sh.up      <= time_up;
                sh.down    <= time_down;
                sh.period  <= period;
                sh.num_pix <= num_pix;
            end
            if (cfg_set)     cfg_err <= 1'b1;
            else if (accept) cfg_err <= 1'b0;

            // counting only continues while staying in RUN; every other path restarts at 0
            tcount <= (state_q == S_RUN && state_d == S_RUN) ? tcount + T_ONE : '0;

            if (accept)
                pix_idx <= '0;
            else if (state_q == S_WAIT && state_d == S_RUN)
                pix_idx <= pix_idx + P_ONE;

            phase_o <= (state_q == S_RUN && state_d != S_IDLE) ? hit : '0;
        end
    end
endmodule
